// File: rtl/bldc_rpm_calculator_if.sv
// RPM request/response bundle between the hall sequencer and the RPM calculator.
interface bldc_rpm_calculator_if;
    logic        i_get_rpm;
    logic [31:0] i_time_count;
    logic [12:0] o_rpm;
    logic        o_valid;
    logic        o_busy;
    logic        o_saturated;

    // Controller side: issues requests, consumes results
    modport master (
        output i_get_rpm,
        output i_time_count,
        input  o_rpm,
        input  o_valid,
        input  o_busy,
        input  o_saturated
    );

    // Calculator side: accepts requests, produces results
    modport slave (
        input  i_get_rpm,
        input  i_time_count,
        output o_rpm,
        output o_valid,
        output o_busy,
        output o_saturated
    );
endinterface

// File: rtl/bldc_rpm_calculator.sv
// Converts a hall-sector period count into mechanical RPM with a 32-step
// restoring divider; result saturates at RPM_MAX and is strobed by o_valid.
module bldc_rpm_calculator #(
    parameter int unsigned     CLK_FREQ   = 100000000,
    parameter int unsigned     POLE_PAIRS = 4,
    parameter longint unsigned NUMERATOR  = (64'(60) * 64'(CLK_FREQ)) / (64'(6) * 64'(POLE_PAIRS)),
    parameter int unsigned     RPM_MAX    = 8191
) (
    input  logic                  i_clk,
    input  logic                  i_n_reset,
    bldc_rpm_calculator_if.slave  bus
);

    localparam int unsigned TW = 32;
    localparam int unsigned RW = 13;
    localparam int unsigned CW = 6;
    localparam logic [TW-1:0] NUM_K   = TW'(NUMERATOR);
    localparam logic [TW-1:0] MAX_K   = TW'(RPM_MAX);
    localparam logic [CW-1:0] STEPS_K = CW'(TW);

    // Divide constant must fit the 32-bit dividend register
    if (NUMERATOR >= 64'h1_0000_0000) begin : g_num_range
        $error("NUMERATOR does not fit in 32 bits");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] dvs_q, dvs_d;
    logic [TW-1:0] dvd_q, dvd_d;
    logic [TW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rpm_q, rpm_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          sat_q, sat_d;
    logic [TW:0]   rem_sh;

    // Next-state, divider datapath and result formatting
    always_comb begin
        state_d = state_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        rpm_d   = rpm_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        sat_d   = sat_q;
        rem_sh  = {rem_q, dvd_q[TW-1]};

        case (state_q)
            S_IDLE: begin
                if (bus.i_get_rpm) begin
                    dvs_d   = bus.i_time_count;
                    dvd_d   = NUM_K;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (dvs_q == '0) begin
                    // Zero period: skip the division, report 0 RPM
                    dvd_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == STEPS_K) begin
                    state_d = S_DONE;
                end else begin
                    // Dividend register shifts out its MSB and collects quotient bits
                    if (rem_sh >= {1'b0, dvs_q}) begin
                        rem_d = TW'(rem_sh - {1'b0, dvs_q});
                        dvd_d = {dvd_q[TW-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[TW-1:0];
                        dvd_d = {dvd_q[TW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (dvd_q > MAX_K) begin
                    rpm_d = RW'(RPM_MAX);
                    sat_d = 1'b1;
                end else begin
                    rpm_d = dvd_q[RW-1:0];
                    sat_d = 1'b0;
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q <= S_IDLE;
            dvs_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            rpm_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            rpm_q   <= rpm_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.o_rpm       = rpm_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_saturated = sat_q;

endmodule

// File: tb/tb_bldc_rpm_calculator.sv
// Directed bench for bldc_rpm_calculator: latency, saturation, zero period,
// request dropping, back-to-back, level-held request and mid-division reset.
module tb_bldc_rpm_calculator;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   valid_cnt;
    int   busy_cnt;

    bldc_rpm_calculator_if bus ();

    bldc_rpm_calculator dut (
        .i_clk     (clk),
        .i_n_reset (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index, bumped on every rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled on the falling edge
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (bus.o_busy === 1'b1)  busy_cnt  <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request; s returns the cycle index just after the sampling edge
    task automatic pulse(input logic [31:0] tc, output int s);
        bus.i_get_rpm    = 1'b1;
        bus.i_time_count = tc;
        @(posedge clk);
        #1;
        bus.i_get_rpm = 1'b0;
        s = cyc;
    endtask

    // Wait (bounded) for the next o_valid; returns at the falling edge of that cycle
    task automatic wait_valid(output bit got);
        int v0;
        v0  = valid_cnt;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (valid_cnt != v0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // One complete request with expected latency and result
    task automatic req(input string tag, input logic [31:0] tc, input int lat,
                       input logic [12:0] rpm, input logic sat);
        int s;
        bit got;
        pulse(tc, s);
        wait_valid(got);
        chk({tag, "_got"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(cyc - s), 32'(lat));
        chk({tag, "_rpm"}, 32'(bus.o_rpm), 32'(rpm));
        chk({tag, "_sat"}, 32'(bus.o_saturated), 32'(sat));
    endtask

    initial begin
        int  s;
        int  b0;
        int  v0;
        bit  got;

        checks           = 0;
        failures         = 0;
        cyc              = 0;
        valid_cnt        = 0;
        busy_cnt         = 0;
        rst_n            = 1'b0;
        bus.i_get_rpm    = 1'b0;
        bus.i_time_count = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rpm",   32'(bus.o_rpm), 32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_busy",  32'(bus.o_busy), 32'd0);
        chk("rst_sat",   32'(bus.o_saturated), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic request: latency, busy window, single-cycle strobe, held result
        b0 = busy_cnt;
        pulse(32'd250000, s);
        chk("t1_busy_rise", 32'(bus.o_busy), 32'd1);
        wait_valid(got);
        chk("t1_got",   32'(got), 32'd1);
        chk("t1_lat",   32'(cyc - s), 32'd34);
        chk("t1_rpm",   32'(bus.o_rpm), 32'd1000);
        chk("t1_sat",   32'(bus.o_saturated), 32'd0);
        chk("t1_busy_in_valid", 32'(bus.o_busy), 32'd0);
        chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd34);
        @(negedge clk);
        #1;
        chk("t1_valid_width", 32'(bus.o_valid), 32'd0);
        chk("t1_rpm_held",    32'(bus.o_rpm), 32'd1000);

        // Ordinary and extreme periods
        req("t2a", 32'd1000000, 34, 13'd250, 1'b0);
        req("t2b", 32'hFFFF_FFFF, 34, 13'd0, 1'b0);

        // Saturation boundary
        req("t3a", 32'd30000, 34, 13'd8191, 1'b1);
        req("t3b", 32'd31000, 34, 13'd8064, 1'b0);

        // Zero period: no division, fast completion
        req("t4", 32'd0, 2, 13'd0, 1'b0);

        // Request while busy is ignored; input changes mid-division have no effect
        pulse(32'd250000, s);
        repeat (9) @(posedge clk);
        #1;
        bus.i_get_rpm    = 1'b1;
        bus.i_time_count = 32'd125000;
        @(posedge clk);
        #1;
        bus.i_get_rpm    = 1'b0;
        bus.i_time_count = 32'd7;
        wait_valid(got);
        chk("t5_got", 32'(got), 32'd1);
        chk("t5_lat", 32'(cyc - s), 32'd34);
        chk("t5_rpm", 32'(bus.o_rpm), 32'd1000);

        // Back-to-back: new request accepted in the o_valid cycle
        req("t5b", 32'd125000, 34, 13'd2000, 1'b0);
        v0 = valid_cnt;
        repeat (40) @(negedge clk);
        #1;
        chk("t5_no_extra_valid", 32'(valid_cnt - v0), 32'd0);

        // Level-held request re-triggers on each return to idle
        bus.i_get_rpm    = 1'b1;
        bus.i_time_count = 32'd1000000;
        @(posedge clk);
        #1;
        s = cyc;
        wait_valid(got);
        chk("t6_got1", 32'(got), 32'd1);
        chk("t6_lat1", 32'(cyc - s), 32'd34);
        chk("t6_rpm1", 32'(bus.o_rpm), 32'd250);
        s = cyc;
        wait_valid(got);
        bus.i_get_rpm = 1'b0;
        chk("t6_got2", 32'(got), 32'd1);
        chk("t6_gap",  32'(cyc - s), 32'd35);
        chk("t6_rpm2", 32'(bus.o_rpm), 32'd250);
        v0 = valid_cnt;
        repeat (40) @(negedge clk);
        #1;
        chk("t6_stopped", 32'(valid_cnt - v0), 32'd0);

        // Reset mid-division aborts with no result
        pulse(32'd250000, s);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_rpm",  32'(bus.o_rpm), 32'd0);
        chk("t7_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("t7_rst_sat",  32'(bus.o_saturated), 32'd0);
        v0 = valid_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("t7_no_valid", 32'(valid_cnt - v0), 32'd0);
        req("t7b", 32'd500000, 34, 13'd500, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
